// File: rtl/unidade_controle_jogo_if.sv
// unidade_controle_jogo_if: control/status bundle between the game FSM and its datapath
interface unidade_controle_jogo_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fim;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       acertou;
  logic       errou;
  logic       pronto;
  logic       db_timeout;
  logic [3:0] db_estado;
  modport master (
    output iniciar, jogada, igual, fim,
    input  zeraC, contaC, zeraR, registraR, acertou, errou, pronto, db_timeout, db_estado
  );
  modport slave (
    input  iniciar, jogada, igual, fim,
    output zeraC, contaC, zeraR, registraR, acertou, errou, pronto, db_timeout, db_estado
  );
endinterface

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing one 16-play memory-game round with per-play timeout
module unidade_controle_jogo #(
  parameter int TIMEOUT = 5000
) (
  input logic                     clock,
  input logic                     reset,
  unidade_controle_jogo_if.slave  bus
);
  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LIM = W'(TIMEOUT - 1);
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hC,
    FIM_ERRO    = 4'hE
  } estado_t;
  estado_t      estado_q, estado_d;
  logic [W-1:0] cnt_q;
  logic         zerac_q, contac_q, zerar_q, registrar_q;
  logic         acertou_q, errou_q, pronto_q, timeout_q;
  // next-state selection; a play beats the timeout in the same cycle
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:     estado_d = bus.iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  estado_d = ESPERA;
      ESPERA:      estado_d = bus.jogada ? REGISTRA : (cnt_q == LIM) ? FIM_TIMEOUT : ESPERA;
      REGISTRA:    estado_d = COMPARACAO;
      COMPARACAO:  estado_d = !bus.igual ? FIM_ERRO : bus.fim ? FIM_ACERTO : PROXIMO;
      PROXIMO:     estado_d = ESPERA;
      FIM_ACERTO:  estado_d = bus.iniciar ? PREPARACAO : FIM_ACERTO;
      FIM_TIMEOUT: estado_d = bus.iniciar ? PREPARACAO : FIM_TIMEOUT;
      FIM_ERRO:    estado_d = bus.iniciar ? PREPARACAO : FIM_ERRO;
      default:     estado_d = INICIAL;
    endcase
  end
  // state, saturating timeout counter and outputs decoded from the next state so they track the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= INICIAL;
      cnt_q       <= '0;
      zerac_q     <= 1'b0;
      contac_q    <= 1'b0;
      zerar_q     <= 1'b0;
      registrar_q <= 1'b0;
      acertou_q   <= 1'b0;
      errou_q     <= 1'b0;
      pronto_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= (estado_q == PREPARACAO || estado_q == PROXIMO) ? '0 :
                     (estado_q == ESPERA && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
      zerac_q     <= estado_d == PREPARACAO;
      contac_q    <= estado_d == PROXIMO;
      zerar_q     <= estado_d == PREPARACAO;
      registrar_q <= estado_d == REGISTRA;
      acertou_q   <= estado_d == FIM_ACERTO;
      errou_q     <= estado_d == FIM_ERRO || estado_d == FIM_TIMEOUT;
      pronto_q    <= estado_d == FIM_ACERTO || estado_d == FIM_ERRO || estado_d == FIM_TIMEOUT;
      timeout_q   <= estado_d == FIM_TIMEOUT;
    end
  end
  assign bus.zeraC      = zerac_q;
  assign bus.contaC     = contac_q;
  assign bus.zeraR      = zerar_q;
  assign bus.registraR  = registrar_q;
  assign bus.acertou    = acertou_q;
  assign bus.errou      = errou_q;
  assign bus.pronto     = pronto_q;
  assign bus.db_timeout = timeout_q;
  assign bus.db_estado  = estado_q;
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: directed self-checking bench for the game control FSM
module tb_unidade_controle_jogo;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n_conta = 0;
  unidade_controle_jogo_if bus ();
  unidade_controle_jogo #(.TIMEOUT(50)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [7:0] outs();
    return {bus.zeraC, bus.contaC, bus.zeraR, bus.registraR, bus.acertou, bus.errou, bus.pronto, bus.db_timeout};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (bus.contaC) n_conta++;
    end
  endtask
  task automatic play(input logic ig, input logic fm);
    bus.igual = ig;
    bus.fim = fm;
    bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
  endtask
  initial begin
    bus.iniciar = 1'b0;
    bus.jogada = 1'b0;
    bus.igual = 1'b0;
    bus.fim = 1'b0;
    #3;
    chk("reset_state", bus.db_estado, 4'h0);
    chk("reset_outs", outs(), 8'h00);
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("idle_state", bus.db_estado, 4'h0);
    chk("idle_outs", outs(), 8'h00);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    chk("prep_state", bus.db_estado, 4'h1);
    chk("prep_outs", outs(), 8'b1010_0000);
    tick();
    chk("wait_state", bus.db_estado, 4'h2);
    chk("wait_outs", outs(), 8'h00);
    n_conta = 0;
    for (int i = 0; i < 16; i++) begin
      play(1'b1, i == 15);
      if (i == 0) begin
        chk("reg_state", bus.db_estado, 4'h4);
        chk("reg_outs", outs(), 8'b0001_0000);
      end
      tick();
      if (i == 0) chk("cmp_state", bus.db_estado, 4'h5);
      tick();
      if (i < 15) begin
        if (i == 0) chk("prox_outs", outs(), 8'b0100_0000);
        tick();
      end
    end
    chk("ok_state", bus.db_estado, 4'hA);
    chk("ok_outs", outs(), 8'b0000_1010);
    chk("ok_conta", n_conta, 15);
    bus.fim = 1'b0;
    tick(5);
    chk("ok_hold_state", bus.db_estado, 4'hA);
    chk("ok_hold_outs", outs(), 8'b0000_1010);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    chk("restart_state", bus.db_estado, 4'h1);
    tick();
    n_conta = 0;
    for (int i = 0; i < 5; i++) begin
      play(i != 4, 1'b0);
      if (i == 1) bus.iniciar = 1'b1;
      tick(2);
      bus.iniciar = 1'b0;
      if (i < 4) tick();
    end
    chk("err_state", bus.db_estado, 4'hE);
    chk("err_outs", outs(), 8'b0000_0110);
    chk("err_conta", n_conta, 4);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    chk("err_restart_state", bus.db_estado, 4'h1);
    chk("err_restart_outs", outs(), 8'b1010_0000);
    tick();
    chk("to_wait_state", bus.db_estado, 4'h2);
    tick(49);
    chk("to_49_state", bus.db_estado, 4'h2);
    tick();
    chk("to_50_state", bus.db_estado, 4'hC);
    chk("to_outs", outs(), 8'b0000_0111);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick();
    tick(49);
    chk("edge_wait_state", bus.db_estado, 4'h2);
    play(1'b1, 1'b0);
    chk("edge_play_state", bus.db_estado, 4'h4);
    tick(3);
    chk("edge_back_state", bus.db_estado, 4'h2);
    tick(49);
    chk("cleared_49_state", bus.db_estado, 4'h2);
    tick();
    chk("cleared_50_state", bus.db_estado, 4'hC);
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    tick(3);
    chk("mid_wait_state", bus.db_estado, 4'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_state", bus.db_estado, 4'h0);
    chk("async_outs", outs(), 8'h00);
    reset = 1'b0;
    bus.jogada = 1'b1;
    tick();
    bus.jogada = 1'b0;
    chk("post_reset_state", bus.db_estado, 4'h0);
    chk("post_reset_outs", outs(), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
